// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//  Types and helpers shared by the UART receiver and transmitter.
//  - rx_state_e   : receiver frame FSM states
//  - PARITY_ODD / PARITY_EVEN : encoding of the parity_type configuration bit
//  - data_bits()  : converts the 2-bit data length code into 5..8
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    localparam logic PARITY_ODD  = 1'b0;
    localparam logic PARITY_EVEN = 1'b1;

    // 00=5, 01=6, 10=7, 11=8 data bits
    function automatic logic [3:0] data_bits(input logic [1:0] num);
        return 4'd5 + {2'b00, num};
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
//  Register-block side of the UART receiver: frame configuration, the
//  read strobe and the one-entry holding register with its status flags.
//  master : register block (drives config and rx_rd_i)
//  slave  : uart_rx (drives data, avail and error/overrun flags)
// ---------------------------------------------------------------------------
interface uart_rx_if;

    logic [1:0] data_bit_num_i;
    logic       parity_en_i;
    logic       parity_type_i;
    logic       stop_bit_num_i;
    logic       rx_rd_i;
    logic [7:0] rx_data_o;
    logic       rx_avail_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       overrun_o;

    modport master (
        output data_bit_num_i, parity_en_i, parity_type_i, stop_bit_num_i, rx_rd_i,
        input  rx_data_o, rx_avail_o, parity_err_o, frame_err_o, overrun_o
    );

    modport slave (
        input  data_bit_num_i, parity_en_i, parity_type_i, stop_bit_num_i, rx_rd_i,
        output rx_data_o, rx_avail_o, parity_err_o, frame_err_o, overrun_o
    );

endinterface

// File: rtl/uart_sync.sv
// ---------------------------------------------------------------------------
// uart_sync
//  Multi-flop synchroniser for an asynchronous single-bit input.
//  Flops reset to 1 so an idle-high serial line does not look like a start
//  bit while reset is released.
//  Ports: clk, rst (async, active high), d (async input), q (synchronised)
// ---------------------------------------------------------------------------
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;
    logic [STAGES-1:0] sync_next;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_next[gi] = d;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= sync_next;
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//  UART serial receiver. Oversamples the synchronised rx line with rx_tick,
//  deserialises 5..8 data bits LSB-first, checks optional parity and 1 or 2
//  stop bits, and delivers the frame to a one-entry holding register.
//  Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   rx_tick   : 1-cycle pulse, OVERSAMPLE per bit period
//   rx        : serial input, idle high, asynchronous to clk
//   rts_n     : high = do not send (holding register full, or in reset)
//   bus       : register-block interface (config, read strobe, data, flags)
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx_tick,
    input  logic      rx,
    output logic      rts_n,
    uart_rx_if.slave  bus
);

    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam logic [SCNT_W-1:0] SCNT_MID = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] SCNT_END = SCNT_W'(OVERSAMPLE - 1);

    logic rx_s;

    // frame FSM state
    rx_state_e         state_reg;
    logic [SCNT_W-1:0] scnt_reg;
    logic [2:0]        bit_cnt_reg;
    logic [7:0]        shift_reg;
    logic [3:0]        nbits_reg;
    logic              par_en_reg;
    logic              par_type_reg;
    logic              stop2_reg;
    logic              stop_cnt_reg;
    logic              perr_reg;
    logic              ferr_reg;
    logic              wait_high_reg;

    // holding register
    logic [7:0] data_reg;
    logic       avail_reg;
    logic       perr_hold_reg;
    logic       ferr_hold_reg;
    logic       overrun_reg;
    logic       rts_n_reg;

    logic sample;
    logic last_data;
    logic last_stop;
    logic commit;
    logic frame_ferr;
    logic parity_err_now;
    logic accept;
    logic avail_next;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign sample    = rx_tick && (scnt_reg == SCNT_END);
    assign last_data = ({1'b0, bit_cnt_reg} == (nbits_reg - 4'd1));
    assign last_stop = (stop_cnt_reg == stop2_reg);
    // The commit cycle is the tick that samples the final stop bit.
    assign commit     = (state_reg == RX_STOP) && sample && last_stop;
    assign frame_ferr = ferr_reg | ~rx_s;
    // Odd parity expects the XOR over data+parity to be 1, even expects 0.
    // Unused data MSBs are zero so they do not disturb the reduction.
    assign parity_err_now = ((^shift_reg) ^ rx_s) != (par_type_reg == PARITY_ODD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= RX_IDLE;
            scnt_reg      <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            nbits_reg     <= '0;
            par_en_reg    <= 1'b0;
            par_type_reg  <= 1'b0;
            stop2_reg     <= 1'b0;
            stop_cnt_reg  <= 1'b0;
            perr_reg      <= 1'b0;
            ferr_reg      <= 1'b0;
            wait_high_reg <= 1'b0;
        end else begin
            case (state_reg)
                RX_IDLE: begin
                    // After a frame ending on a low stop sample (break), the
                    // line must return high before a new start is accepted.
                    if (wait_high_reg) begin
                        if (rx_s) begin
                            wait_high_reg <= 1'b0;
                        end
                    end else if (rx_tick && !rx_s) begin
                        state_reg    <= RX_START;
                        scnt_reg     <= '0;
                        shift_reg    <= '0;
                        nbits_reg    <= data_bits(bus.data_bit_num_i);
                        par_en_reg   <= bus.parity_en_i;
                        par_type_reg <= bus.parity_type_i;
                        stop2_reg    <= bus.stop_bit_num_i;
                        stop_cnt_reg <= 1'b0;
                        perr_reg     <= 1'b0;
                        ferr_reg     <= 1'b0;
                    end
                end
                RX_START: begin
                    if (rx_tick) begin
                        if (scnt_reg == SCNT_MID) begin
                            scnt_reg    <= '0;
                            bit_cnt_reg <= '0;
                            // a start bit that is gone by mid-bit was a glitch
                            state_reg   <= rx_s ? RX_IDLE : RX_DATA;
                        end else begin
                            scnt_reg <= scnt_reg + SCNT_W'(1);
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        if (sample) begin
                            scnt_reg               <= '0;
                            shift_reg[bit_cnt_reg] <= rx_s;
                            bit_cnt_reg            <= bit_cnt_reg + 3'd1;
                            if (last_data) begin
                                state_reg <= par_en_reg ? RX_PARITY : RX_STOP;
                            end
                        end else begin
                            scnt_reg <= scnt_reg + SCNT_W'(1);
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_tick) begin
                        if (sample) begin
                            scnt_reg  <= '0;
                            perr_reg  <= parity_err_now;
                            state_reg <= RX_STOP;
                        end else begin
                            scnt_reg <= scnt_reg + SCNT_W'(1);
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        if (sample) begin
                            scnt_reg <= '0;
                            if (!rx_s) begin
                                ferr_reg <= 1'b1;
                            end
                            if (last_stop) begin
                                state_reg     <= RX_IDLE;
                                wait_high_reg <= ~rx_s;
                            end else begin
                                stop_cnt_reg <= 1'b1;
                            end
                        end else begin
                            scnt_reg <= scnt_reg + SCNT_W'(1);
                        end
                    end
                end
                default: state_reg <= RX_IDLE;
            endcase
        end
    end

    // A read in the commit cycle frees the slot for the new frame.
    assign accept     = commit && (!avail_reg || bus.rx_rd_i);
    assign avail_next = accept || (avail_reg && !bus.rx_rd_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg      <= '0;
            avail_reg     <= 1'b0;
            perr_hold_reg <= 1'b0;
            ferr_hold_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            rts_n_reg     <= 1'b1;
        end else begin
            avail_reg   <= avail_next;
            rts_n_reg   <= avail_next;
            overrun_reg <= commit && !accept;
            if (accept) begin
                data_reg      <= shift_reg;
                perr_hold_reg <= perr_reg;
                ferr_hold_reg <= frame_ferr;
            end
        end
    end

    assign bus.rx_data_o    = data_reg;
    assign bus.rx_avail_o   = avail_reg;
    assign bus.parity_err_o = perr_hold_reg;
    assign bus.frame_err_o  = ferr_hold_reg;
    assign bus.overrun_o    = overrun_reg;
    assign rts_n            = rts_n_reg;

endmodule
